// File: rtl/obi_arb_pkg.sv
// rtl/obi_arb_pkg.sv - shared types and constants for the OBI RAM arbiter
package obi_arb_pkg;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_port_e;

    typedef struct packed {
        logic      valid;
        arb_port_e port;
    } owner_t;

    localparam int RAM_LATENCY = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-granted register
module rr_arb2
    import obi_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    arb_port_e last_q;

    // Lone requester wins outright; on a conflict the port not granted last wins
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[INSTR] && req_i[DATA]) begin
            if (last_q == DATA) begin
                gnt_o[INSTR] = 1'b1;
            end else begin
                gnt_o[DATA] = 1'b1;
            end
        end else begin
            gnt_o = req_i;
        end
    end

    // Remember the most recently granted port; DATA at reset so INSTR wins first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= DATA;
        end else if (gnt_o[DATA]) begin
            last_q <= DATA;
        end else if (gnt_o[INSTR]) begin
            last_q <= INSTR;
        end
    end

endmodule

// File: rtl/obi_ram_arbiter.sv
// rtl/obi_ram_arbiter.sv - OBI instr/data arbiter onto one RAM port (optional stats: ARB_STATS_EN)
module obi_ram_arbiter
    import obi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    output logic [CNT_WIDTH-1:0]  stat_instr_gnt_o,
    output logic [CNT_WIDTH-1:0]  stat_data_gnt_o,
    output logic [CNT_WIDTH-1:0]  stat_conflict_o
);

    logic [1:0] req;
    logic [1:0] gnt;
    owner_t     owner_q;
    logic       write_q;

    // Address bits above the RAM window are deliberately dropped (wrap)
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH], data_addr_i[31:ADDR_WIDTH]};

    assign req[INSTR] = instr_req_i;
    assign req[DATA]  = data_req_i;

    rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign instr_gnt_o = gnt[INSTR];
    assign data_gnt_o  = gnt[DATA];

    // Drive the RAM port from whichever requester holds the grant, zeros when idle
    always_comb begin
        ram_en_o    = gnt[INSTR] | gnt[DATA];
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_wdata_o = 32'h0;
        if (gnt[DATA]) begin
            ram_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
            ram_we_o    = data_we_i;
            ram_be_o    = data_be_i;
            ram_wdata_o = data_wdata_i;
        end else if (gnt[INSTR]) begin
            ram_addr_o = instr_addr_i[ADDR_WIDTH-1:0];
            ram_be_o   = 4'hF;
        end
    end

    // Track who owns the response arriving from the RAM next cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= '{valid: 1'b0, port: INSTR};
            write_q <= 1'b0;
        end else begin
            owner_q.valid <= gnt[INSTR] | gnt[DATA];
            owner_q.port  <= gnt[DATA] ? DATA : INSTR;
            write_q       <= gnt[DATA] & data_we_i;
        end
    end

    // Route the RAM read data to the owning port only; write responses carry no data
    always_comb begin
        instr_rvalid_o = owner_q.valid && (owner_q.port == INSTR);
        data_rvalid_o  = owner_q.valid && (owner_q.port == DATA);
        instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && !write_q) ? ram_rdata_i : 32'h0;
    end

`ifdef ARB_STATS_EN
    logic [CNT_WIDTH-1:0] instr_cnt_q;
    logic [CNT_WIDTH-1:0] data_cnt_q;
    logic [CNT_WIDTH-1:0] conflict_cnt_q;

    // Saturating grant and conflict counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_cnt_q    <= '0;
            data_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (gnt[INSTR] && !(&instr_cnt_q)) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
            if (gnt[DATA] && !(&data_cnt_q)) begin
                data_cnt_q <= data_cnt_q + 1'b1;
            end
            if (req[INSTR] && req[DATA] && !(&conflict_cnt_q)) begin
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
            end
        end
    end

    assign stat_instr_gnt_o = instr_cnt_q;
    assign stat_data_gnt_o  = data_cnt_q;
    assign stat_conflict_o  = conflict_cnt_q;
`else
    assign stat_instr_gnt_o = '0;
    assign stat_data_gnt_o  = '0;
    assign stat_conflict_o  = '0;
`endif

endmodule

// File: tb/tb_obi_ram_arbiter.sv
// tb/tb_obi_ram_arbiter.sv - scoreboard bench for obi_ram_arbiter
module tb_obi_ram_arbiter;

    localparam int AW = 22;
    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          instr_req_i;
    logic          instr_gnt_o;
    logic [31:0]   instr_addr_i;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i;
    logic          data_gnt_o;
    logic [31:0]   data_addr_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [31:0]   data_wdata_i;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i;
    logic [CW-1:0] stat_instr_gnt_o;
    logic [CW-1:0] stat_data_gnt_o;
    logic [CW-1:0] stat_conflict_o;

    int n_vec = 0;
    int n_err = 0;

    logic        sb_port[$];
    logic [31:0] sb_data[$];

    logic [31:0] mem [int unsigned];

    localparam logic [31:0] W_INSTR = 32'h0000_0013;
    localparam logic [31:0] W_DATA  = 32'hA5A5_0F0F;

    always #5 clk_i = ~clk_i;

    obi_ram_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .instr_req_i      (instr_req_i),
        .instr_gnt_o      (instr_gnt_o),
        .instr_addr_i     (instr_addr_i),
        .instr_rvalid_o   (instr_rvalid_o),
        .instr_rdata_o    (instr_rdata_o),
        .data_req_i       (data_req_i),
        .data_gnt_o       (data_gnt_o),
        .data_addr_i      (data_addr_i),
        .data_we_i        (data_we_i),
        .data_be_i        (data_be_i),
        .data_wdata_i     (data_wdata_i),
        .data_rvalid_o    (data_rvalid_o),
        .data_rdata_o     (data_rdata_o),
        .ram_en_o         (ram_en_o),
        .ram_addr_o       (ram_addr_o),
        .ram_we_o         (ram_we_o),
        .ram_be_o         (ram_be_o),
        .ram_wdata_o      (ram_wdata_o),
        .ram_rdata_i      (ram_rdata_i),
        .stat_instr_gnt_o (stat_instr_gnt_o),
        .stat_data_gnt_o  (stat_data_gnt_o),
        .stat_conflict_o  (stat_conflict_o)
    );

    function automatic logic [31:0] mem_rd(input int unsigned idx);
        if (mem.exists(idx)) return mem[idx];
        return 32'h0;
    endfunction

    // Single-port RAM model, one cycle read latency, byte-enabled writes
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            int unsigned idx;
            logic [31:0] w;
            idx = int'(ram_addr_o[AW-1:2]);
            w = mem_rd(idx);
            ram_rdata_i <= w;
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) w[8*b +: 8] = ram_wdata_o[8*b +: 8];
                end
                mem[idx] = w;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_resp();
        if (sb_port.size() > 0) begin
            logic        p;
            logic [31:0] d;
            p = sb_port.pop_front();
            d = sb_data.pop_front();
            chk("instr_rvalid", instr_rvalid_o, p == 1'b0);
            chk("data_rvalid", data_rvalid_o, p == 1'b1);
            chk("instr_rdata", instr_rdata_o, (p == 1'b0) ? d : 32'h0);
            chk("data_rdata", data_rdata_o, (p == 1'b1) ? d : 32'h0);
        end else begin
            chk("idle_instr_rvalid", instr_rvalid_o, 1'b0);
            chk("idle_data_rvalid", data_rvalid_o, 1'b0);
        end
    endtask

    // eg: expected grant 0 none, 1 instr, 2 data; erd: expected response data
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da, input logic dwe,
                        input logic [3:0] dbe, input logic [31:0] dwd,
                        input int eg, input logic [31:0] erd);
        @(negedge clk_i);
        check_resp();
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_wdata_i = dwd;
        #1;
        chk("instr_gnt", instr_gnt_o, eg == 1);
        chk("data_gnt", data_gnt_o, eg == 2);
        chk("ram_en", ram_en_o, eg != 0);
        if (eg == 1) begin
            chk("ram_addr_i", ram_addr_o, ia[AW-1:0]);
            chk("ram_we_i", ram_we_o, 1'b0);
            chk("ram_be_i", ram_be_o, 4'hF);
            sb_port.push_back(1'b0);
            sb_data.push_back(erd);
        end else if (eg == 2) begin
            chk("ram_addr_d", ram_addr_o, da[AW-1:0]);
            chk("ram_we_d", ram_we_o, dwe);
            chk("ram_be_d", ram_be_o, dbe);
            chk("ram_wdata_d", ram_wdata_o, dwd);
            sb_port.push_back(1'b1);
            sb_data.push_back(erd);
        end else begin
            chk("ram_we_idle", ram_we_o, 1'b0);
            chk("ram_addr_idle", ram_addr_o, '0);
            chk("ram_be_idle", ram_be_o, 4'h0);
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic contend(input int eg);
        step(1'b1, 32'h180, 1'b1, 32'h2000, 1'b0, 4'hF, 32'h0, eg,
             (eg == 1) ? W_INSTR : W_DATA);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        rst_i = 1'b1;
        #1;
        sb_port.delete();
        sb_data.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        mem[32'h180 >> 2]  = W_INSTR;
        mem[32'h2000 >> 2] = W_DATA;
        ram_rdata_i  = 32'h0;
        rst_i        = 1'b1;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_wdata_i = 32'h0;

        // Reset state: grants still combinational, no responses, counters clear
        #1;
        instr_req_i = 1'b1;
        #1;
        chk("rst_instr_gnt", instr_gnt_o, 1'b1);
        chk("rst_data_gnt", data_gnt_o, 1'b0);
        chk("rst_instr_rvalid", instr_rvalid_o, 1'b0);
        chk("rst_data_rvalid", data_rvalid_o, 1'b0);
        chk("rst_stat_i", stat_instr_gnt_o, '0);
        chk("rst_stat_d", stat_data_gnt_o, '0);
        chk("rst_stat_c", stat_conflict_o, '0);
        instr_req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Continuous contention from reset alternates INSTR, DATA, ...
        for (int i = 0; i < 6; i++) contend((i % 2 == 0) ? 1 : 2);
        idle();

        // Instruction-only fetch
        step(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1, W_INSTR);
        idle();

        // Partial write then readback
        step(1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 4'b0011, 32'hDEADBEEF, 2, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 4'hF, 32'h0, 2, 32'h0000BEEF);
        idle();

        // Address wrap above the RAM window
        step(1'b1, 32'hFFC00180, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1, W_INSTR);
        idle();

        // Reset right after a data grant drops the pending response
        step(1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 4'hF, 32'h0, 2, W_DATA);
        @(negedge clk_i);
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("drop_data_rvalid", data_rvalid_o, 1'b0);
        chk("drop_instr_rvalid", instr_rvalid_o, 1'b0);
        sb_port.delete();
        sb_data.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        contend(1);
        idle();

        // Statistics: 10 contended cycles plus 3 instruction-only
        pulse_reset();
        for (int i = 0; i < 10; i++) contend((i % 2 == 0) ? 1 : 2);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1, W_INSTR);
        idle();
`ifdef ARB_STATS_EN
        chk("stat_instr", stat_instr_gnt_o, 8);
        chk("stat_data", stat_data_gnt_o, 5);
        chk("stat_conflict", stat_conflict_o, 10);
`else
        chk("stat_instr", stat_instr_gnt_o, 0);
        chk("stat_data", stat_data_gnt_o, 0);
        chk("stat_conflict", stat_conflict_o, 0);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
